// File: rtl/imem_loader.sv
// Instruction-memory program-port loader: packs host bytes little-endian into words,
// writes them to consecutive addresses, then reads the region back and compares sums.
module imem_loader #(
    parameter int unsigned ADDR_STEP    = 4,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] word_count,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        prg_mode,
    output logic        prg_we,
    output logic [31:0] prg_addr,
    output logic [31:0] prg_wd,
    input  logic [31:0] prg_rd,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam int LW = $clog2(READ_LATENCY) + 1;

    typedef enum logic [2:0] {
        IDLE, RECV, WRITE, VRD_ADDR, VRD_WAIT, CHECK, DONE
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    addr_q, addr_d, wd_q, wd_d, base_q, base_d;
    logic [31:0]    cks_q, cks_d, rsum_q, rsum_d;
    logic [15:0]    cnt_q, cnt_d, rem_q, rem_d;
    logic [1:0]     bcnt_q, bcnt_d;
    logic [LW-1:0]  lat_q, lat_d;
    logic           busy_q, busy_d, mode_q, mode_d, done_q, done_d, err_q, err_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wd_q    <= '0;
            base_q  <= '0;
            cks_q   <= '0;
            rsum_q  <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            bcnt_q  <= '0;
            lat_q   <= '0;
            busy_q  <= 1'b0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            base_q  <= base_d;
            cks_q   <= cks_d;
            rsum_q  <= rsum_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            bcnt_q  <= bcnt_d;
            lat_q   <= lat_d;
            busy_q  <= busy_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        base_d  = base_q;
        cks_d   = cks_q;
        rsum_d  = rsum_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        bcnt_d  = bcnt_q;
        lat_d   = lat_q;
        busy_d  = busy_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE: if (start) begin
                addr_d  = base_addr;
                base_d  = base_addr;
                cnt_d   = word_count;
                rem_d   = word_count;
                cks_d   = '0;
                rsum_d  = '0;
                bcnt_d  = '0;
                err_d   = 1'b0;
                busy_d  = 1'b1;
                mode_d  = 1'b1;
                state_d = (word_count == '0) ? DONE : RECV;
            end
            RECV: if (in_valid) begin
                wd_d[{bcnt_q, 3'b000} +: 8] = in_data;
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) state_d = WRITE;
            end
            WRITE: begin
                cks_d = cks_q + wd_q;
                // Last word written: rewind to the base and re-walk the region for verify.
                if (rem_q == 16'd1) begin
                    addr_d  = base_q;
                    rem_d   = cnt_q;
                    state_d = VRD_ADDR;
                end else begin
                    addr_d  = addr_q + 32'(ADDR_STEP);
                    rem_d   = rem_q - 16'd1;
                    state_d = RECV;
                end
            end
            VRD_ADDR: begin
                lat_d   = '0;
                state_d = VRD_WAIT;
            end
            VRD_WAIT: begin
                if (lat_q == LW'(READ_LATENCY - 1)) begin
                    rsum_d  = rsum_q + prg_rd;
                    rem_d   = rem_q - 16'd1;
                    addr_d  = addr_q + 32'(ADDR_STEP);
                    state_d = (rem_q == 16'd1) ? CHECK : VRD_ADDR;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            CHECK: begin
                err_d   = (rsum_q != cks_q);
                state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                mode_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready = (state_q == RECV);
    assign prg_we   = (state_q == WRITE);
    assign prg_addr = addr_q;
    assign prg_wd   = wd_q;
    assign prg_mode = mode_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: synchronous RAM model, write scoreboard, and
// end-of-load status checks across normal, empty, corrupt, gapped, reset and wrap cases.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset_n, start, in_valid;
    logic [31:0] base_addr, prg_addr, prg_wd, prg_rd;
    logic [15:0] word_count;
    logic [7:0]  in_data;
    logic        in_ready, prg_mode, prg_we, busy, done, error;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [logic [31:0]];
    logic [63:0] exp_q [$];
    logic        corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = '0;
    logic        gaps = 1'b0;

    imem_loader #(.ADDR_STEP(4), .READ_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .prg_mode(prg_mode), .prg_we(prg_we),
        .prg_addr(prg_addr), .prg_wd(prg_wd), .prg_rd(prg_rd),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Synchronous RAM, one-cycle read latency, optional single-bit readback fault.
    always @(posedge clk) begin
        logic [31:0] r;
        r = mem.exists(prg_addr) ? mem[prg_addr] : 32'hBAD0_BAD0;
        if (corrupt_en && prg_addr == corrupt_addr) r = r ^ 32'h0000_0010;
        prg_rd <= r;
        if (prg_we) mem[prg_addr] = prg_wd;
    end

    // Write scoreboard: every prg_we cycle must match the next expected address/data.
    always @(negedge clk) begin
        if (prg_we) begin
            check("wr_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("wr_addr", prg_addr, e[63:32]);
                check("wr_data", prg_wd, e[31:0]);
            end
            check("wr_mode", 32'(prg_mode), 32'd1);
        end
    end

    task automatic start_load(input logic [31:0] b, input logic [15:0] n);
        base_addr = b; word_count = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        in_valid = 1'b1; in_data = b;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin
                @(negedge clk);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("byte_timeout", 32'd1, 32'd0);
    endtask

    task automatic send_word(input logic [31:0] a, input logic [31:0] w);
        exp_q.push_back({a, w});
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic wait_done(input string tag, input logic exp_err);
        int n = 0;
        while (!done && n < 200) begin @(negedge clk); n++; end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_mode"}, 32'(prg_mode), 32'd0);
        check({tag, "_err"}, 32'(error), 32'(exp_err));
        check({tag, "_wq"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        base_addr = '0; word_count = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mode", 32'(prg_mode), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_addr", prg_addr, 32'd0);
        check("rst_err", 32'(error), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic two-word load
        start_load(32'h0000_0100, 16'd2);
        check("basic_busy", 32'(busy), 32'd1);
        check("basic_mode", 32'(prg_mode), 32'd1);
        send_word(32'h0000_0100, 32'h1234_5678);
        send_word(32'h0000_0104, 32'hDEAD_BEEF);
        wait_done("basic", 1'b0);

        // Empty load: done two edges after start, no bytes taken
        in_valid = 1'b1; in_data = 8'hA5;
        start_load(32'h0000_0200, 16'd0);
        check("zero_ready", 32'(in_ready), 32'd0);
        check("zero_busy", 32'(busy), 32'd1);
        check("zero_done_early", 32'(done), 32'd0);
        @(negedge clk);
        check("zero_done", 32'(done), 32'd1);
        check("zero_err", 32'(error), 32'd0);
        check("zero_ready2", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);

        // Readback corruption sets a sticky error; next start clears it
        corrupt_en = 1'b1; corrupt_addr = 32'h0000_0104;
        start_load(32'h0000_0100, 16'd2);
        send_word(32'h0000_0100, 32'h1234_5678);
        send_word(32'h0000_0104, 32'hDEAD_BEEF);
        wait_done("corrupt", 1'b1);
        corrupt_en = 1'b0;
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(error), 32'd1);
        start_load(32'h0000_0300, 16'd0);
        check("err_clear", 32'(error), 32'd0);
        repeat (2) @(negedge clk);

        // Gapped input with a stray start mid-load
        gaps = 1'b1;
        start_load(32'h0000_0100, 16'd2);
        send_word(32'h0000_0100, 32'h1234_5678);
        start_load(32'h0000_0900, 16'd5);
        send_word(32'h0000_0104, 32'hDEAD_BEEF);
        wait_done("gaps", 1'b0);
        gaps = 1'b0;

        // Reset after 1.5 words abandons the load
        start_load(32'h0000_0400, 16'd3);
        send_word(32'h0000_0400, 32'hCAFE_F00D);
        send_byte(8'h11); send_byte(8'h22);
        reset_n = 1'b0;
        @(negedge clk);
        check("mrst_mode", 32'(prg_mode), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_we", 32'(prg_we), 32'd0);
        check("mrst_ready", 32'(in_ready), 32'd0);
        check("mrst_addr", prg_addr, 32'd0);
        check("mrst_wd", prg_wd, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mrst_wq", 32'(exp_q.size()), 32'd0);
        start_load(32'h0000_0500, 16'd1);
        send_word(32'h0000_0500, 32'h0BAD_F00D);
        wait_done("fresh", 1'b0);

        // Address wrap past 2^32
        start_load(32'hFFFF_FFFC, 16'd2);
        send_word(32'hFFFF_FFFC, 32'h0102_0304);
        send_word(32'h0000_0000, 32'hA0B0_C0D0);
        wait_done("wrap", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
